// File: rtl/gauss5_pkg.sv
// rtl/gauss5_pkg.sv - shared constants for the 5x5 Gaussian smoothing pipeline
package gauss5_pkg;
  localparam int KERNEL_1D [5] = '{1, 4, 6, 4, 1};
  localparam int NORM_SHIFT = 8;
  localparam int ROUND_BIAS = 128;
  localparam int H_WIDTH = 12;
  localparam int S_WIDTH = 16;
  localparam int PIPE_DEPTH = 3;
endpackage

// File: rtl/gauss_taps_1d.sv
// rtl/gauss_taps_1d.sv - combinational 1-4-6-4-1 weighted sum of five taps
module gauss_taps_1d #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] p0_i,
  input  logic [WIDTH-1:0] p1_i,
  input  logic [WIDTH-1:0] p2_i,
  input  logic [WIDTH-1:0] p3_i,
  input  logic [WIDTH-1:0] p4_i,
  output logic [WIDTH+3:0] sum_o
);
  localparam int OW = WIDTH + 4;

  logic [OW-1:0] e0, e1, e2, e3, e4;

  assign e0 = OW'(p0_i);
  assign e1 = OW'(p1_i);
  assign e2 = OW'(p2_i);
  assign e3 = OW'(p3_i);
  assign e4 = OW'(p4_i);

  // weights total 16, so four extra bits hold the worst case exactly
  assign sum_o = e0 + (e1 << 2) + (e2 << 2) + (e2 << 1) + (e3 << 2) + e4;
endmodule

// File: rtl/gaussian_5x5_filter.sv
// rtl/gaussian_5x5_filter.sv - 3-stage separable 5x5 Gaussian filter with frame counter
module gaussian_5x5_filter
  import gauss5_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] d0_i,
  input  logic [7:0] d1_i,
  input  logic [7:0] d2_i,
  input  logic [7:0] d3_i,
  input  logic [7:0] d4_i,
  input  logic [7:0] d5_i,
  input  logic [7:0] d6_i,
  input  logic [7:0] d7_i,
  input  logic [7:0] d8_i,
  input  logic [7:0] d9_i,
  input  logic [7:0] d10_i,
  input  logic [7:0] d11_i,
  input  logic [7:0] d12_i,
  input  logic [7:0] d13_i,
  input  logic [7:0] d14_i,
  input  logic [7:0] d15_i,
  input  logic [7:0] d16_i,
  input  logic [7:0] d17_i,
  input  logic [7:0] d18_i,
  input  logic [7:0] d19_i,
  input  logic [7:0] d20_i,
  input  logic [7:0] d21_i,
  input  logic [7:0] d22_i,
  input  logic [7:0] d23_i,
  input  logic [7:0] d24_i,
  output logic [7:0] pix_o,
  output logic       valid_o,
  output logic       done_o
);
  localparam int NPIX = ROWS * COLS;
  localparam int CW = $clog2(NPIX + 1);

  logic [7:0] win [25];

  assign win[0]  = d0_i;
  assign win[1]  = d1_i;
  assign win[2]  = d2_i;
  assign win[3]  = d3_i;
  assign win[4]  = d4_i;
  assign win[5]  = d5_i;
  assign win[6]  = d6_i;
  assign win[7]  = d7_i;
  assign win[8]  = d8_i;
  assign win[9]  = d9_i;
  assign win[10] = d10_i;
  assign win[11] = d11_i;
  assign win[12] = d12_i;
  assign win[13] = d13_i;
  assign win[14] = d14_i;
  assign win[15] = d15_i;
  assign win[16] = d16_i;
  assign win[17] = d17_i;
  assign win[18] = d18_i;
  assign win[19] = d19_i;
  assign win[20] = d20_i;
  assign win[21] = d21_i;
  assign win[22] = d22_i;
  assign win[23] = d23_i;
  assign win[24] = d24_i;

  logic [H_WIDTH-1:0]    h_d [5];
  logic [H_WIDTH-1:0]    h_q [5];
  logic [S_WIDTH-1:0]    s_d, s_q;
  logic [7:0]            pix_d, pix_q;
  logic [PIPE_DEPTH-1:0] vld_d, vld_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  logic                  done_d, done_q;
  logic [S_WIDTH:0]      rounded;
  logic [S_WIDTH:0]      scaled;

  for (genvar r = 0; r < 5; r++) begin : g_row
    gauss_taps_1d #(.WIDTH(8)) u_row (
      .p0_i (win[5*r]),
      .p1_i (win[5*r+1]),
      .p2_i (win[5*r+2]),
      .p3_i (win[5*r+3]),
      .p4_i (win[5*r+4]),
      .sum_o(h_d[r])
    );
  end

  gauss_taps_1d #(.WIDTH(H_WIDTH)) u_col (
    .p0_i (h_q[0]),
    .p1_i (h_q[1]),
    .p2_i (h_q[2]),
    .p3_i (h_q[3]),
    .p4_i (h_q[4]),
    .sum_o(s_d)
  );

  always_comb begin
    rounded = {1'b0, s_q} + (S_WIDTH+1)'(ROUND_BIAS);
    scaled  = rounded >> NORM_SHIFT;
    pix_d   = (scaled > (S_WIDTH+1)'(255)) ? 8'hFF : scaled[7:0];
    vld_d   = {vld_q[PIPE_DEPTH-2:0], valid_i};
  end

  // the counter advances on the edge that raises valid_o, so done_o rises with it
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (vld_q[PIPE_DEPTH-2] && !done_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(NPIX)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) h_q[i] <= '0;
      s_q    <= '0;
      pix_q  <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) h_q[i] <= h_d[i];
      s_q    <= s_d;
      pix_q  <= pix_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign pix_o   = pix_q;
  assign valid_o = vld_q[PIPE_DEPTH-1];
  assign done_o  = done_q;
endmodule

// File: tb/tb_gaussian_5x5_filter.sv
// tb/tb_gaussian_5x5_filter.sv - scoreboard bench for gaussian_5x5_filter
module tb_gaussian_5x5_filter;
  import gauss5_pkg::*;

  localparam int NPIX = 49;
  localparam int HIST = 1024;

  typedef logic [7:0] win_t [25];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] d [25];
  logic [7:0] pix_o;
  logic       valid_o;
  logic       done_o;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   outcnt = 0;
  bit   mon_en = 1'b0;
  bit   hist [HIST];
  int   exp_q [$];

  always #5 clk = ~clk;

  gaussian_5x5_filter #(.ROWS(7), .COLS(7)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .d0_i(d[0]), .d1_i(d[1]), .d2_i(d[2]), .d3_i(d[3]), .d4_i(d[4]),
    .d5_i(d[5]), .d6_i(d[6]), .d7_i(d[7]), .d8_i(d[8]), .d9_i(d[9]),
    .d10_i(d[10]), .d11_i(d[11]), .d12_i(d[12]), .d13_i(d[13]), .d14_i(d[14]),
    .d15_i(d[15]), .d16_i(d[16]), .d17_i(d[17]), .d18_i(d[18]), .d19_i(d[19]),
    .d20_i(d[20]), .d21_i(d[21]), .d22_i(d[22]), .d23_i(d[23]), .d24_i(d[24]),
    .pix_o(pix_o), .valid_o(valid_o), .done_o(done_o)
  );

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int ref_pix(input win_t w);
    int s = 0;
    int p;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        s += KERNEL_1D[r] * KERNEL_1D[c] * int'(w[r*5+c]);
    p = (s + 128) / 256;
    return (p > 255) ? 255 : p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: valid_o must repeat the valid_i history three cycles later
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      automatic bit exp_v = (cyc >= 3) ? hist[(cyc-3) % HIST] : 1'b0;
      automatic int e;
      chk("valid_o", int'(valid_o), int'(exp_v));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("pix_o_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_o", int'(pix_o), e);
        end
        outcnt++;
      end
      chk("done_o", int'(done_o), int'(outcnt >= NPIX));
    end
  end

  task automatic clear_model();
    for (int i = 0; i < HIST; i++) hist[i] = 1'b0;
    exp_q.delete();
    outcnt = 0;
  endtask

  task automatic drive(input bit v, input win_t w, input int expected);
    @(posedge clk);
    #1;
    valid_i = v;
    for (int i = 0; i < 25; i++) d[i] = w[i];
    hist[cyc % HIST] = v;
    if (v) exp_q.push_back(expected);
  endtask

  task automatic idle(input int n);
    win_t z;
    for (int i = 0; i < 25; i++) z[i] = 8'd0;
    for (int k = 0; k < n; k++) drive(1'b0, z, 0);
  endtask

  task automatic rand_win(output win_t w);
    for (int i = 0; i < 25; i++) w[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid_i = 1'b0;
    clear_model();
    #1;
    chk("rst_pix_o", int'(pix_o), 0);
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_done_o", int'(done_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    win_t w;
    for (int i = 0; i < 25; i++) d[i] = 8'd0;
    clear_model();
    #1;
    chk("reset_pix_o", int'(pix_o), 0);
    chk("reset_valid_o", int'(valid_o), 0);
    chk("reset_done_o", int'(done_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed windows with hand-computed results
    for (int i = 0; i < 25; i++) w[i] = 8'd100;
    drive(1'b1, w, 100);
    idle(5);
    for (int i = 0; i < 25; i++) w[i] = 8'd0;
    w[12] = 8'd255;
    drive(1'b1, w, 36);
    idle(4);
    for (int i = 0; i < 25; i++) w[i] = 8'd0;
    w[0] = 8'd128;
    drive(1'b1, w, 1);
    w[0] = 8'd127;
    drive(1'b1, w, 0);
    for (int i = 0; i < 25; i++) w[i] = 8'd255;
    drive(1'b1, w, 255);
    idle(5);

    // Full streaming frame plus one extra window
    do_reset();
    for (int n = 0; n < NPIX + 1; n++) begin
      rand_win(w);
      drive(1'b1, w, ref_pix(w));
    end
    idle(5);
    chk("done_sticky", int'(done_o), 1);

    // Gapped stream 1,0,0,1,1,0,1
    for (int n = 0; n < 7; n++) begin
      automatic bit v = (n == 0) || (n == 3) || (n == 4) || (n == 6);
      rand_win(w);
      drive(v, w, ref_pix(w));
    end
    idle(5);

    // Reset mid-frame with windows in flight, then a fresh frame
    do_reset();
    for (int n = 0; n < 20; n++) begin
      rand_win(w);
      drive(1'b1, w, ref_pix(w));
    end
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    chk("pre_reset_valid_o", int'(valid_o), 1);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_pix_o", int'(pix_o), 0);
    chk("async_valid_o", int'(valid_o), 0);
    chk("async_done_o", int'(done_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < NPIX; n++) begin
      rand_win(w);
      drive(1'b1, w, ref_pix(w));
    end
    idle(6);
    chk("frame2_done", int'(done_o), 1);
    chk("frame2_outputs", outcnt, NPIX);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gaussian_5x5_filter.md
# gaussian_5x5_filter

Pipelined 5x5 Gaussian smoothing stage that consumes the zero-padded 25-pixel window from the 5x5 data-modulate stage and produces one filtered 8-bit pixel per valid window. It applies the separable kernel [1 4 6 4 1]ᵀ·[1 4 6 4 1], which sums to 256, with round-half-up normalisation. It also counts output pixels and flags end of frame to the downstream writer.

## Interface
- ROWS, 7, image height in pixels.
- COLS, 7, image width in pixels.

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  window valid; driven by the modulate stage's window-valid strobe.
- d0_i … d24_i  in  8 each  window pixels, row-major (d0 top-left, d12 centre, d24 bottom-right).
- pix_o  out  8  filtered pixel.
- valid_o  out  1  pix_o valid this cycle.
- done_o  out  1  sticky end-of-frame flag.

## Operation
- Row pass (stage 1), per row r in 0..4:
  - h_r = p0 + 4·p1 + 6·p2 + 4·p3 + p4.
  - Unsigned, 12 bits; max 4080.
- Column pass (stage 2):
  - s = h0 + 4·h1 + 6·h2 + 4·h3 + h4.
  - Unsigned, 16 bits; max 65280.
- Normalise (stage 3):
  - pix = (s + 128) >> 8, computed in 17 bits, then clamped to 255.
  - The clamp cannot trigger with legal inputs but is required.
- Valid tracking:
  - valid_i is carried through a 3-bit shift register aligned with data.
  - Data registers load every cycle regardless of valid; only valid_o qualifies pix_o.
- Output counter:
  - Width $clog2(ROWS·COLS+1); increments on each valid_o.
  - When the count reaches ROWS·COLS, done_o is set and the counter freezes.
  - done_o stays high until reset.
  - Windows arriving after done_o are still filtered and flagged by valid_o, but are not counted.
- No backpressure: the block accepts a window every cycle and never stalls.
- Reset (asynchronous, any time, including mid-frame):
  - Clears all pipeline registers, the valid shift register, the counter and done_o.
  - In-flight windows are discarded.
  - The first valid_i after rst_n deasserts is treated as pixel 0 of a new frame.

## Timing
- Reset values: pix_o=0, valid_o=0, done_o=0.
- Latency: valid_i sampled at edge N gives valid_o/pix_o at edge N+3 (registered output).
- Throughput: one pixel per clock; back-to-back and gapped valid_i are both legal.
- Gaps in valid_i propagate as identical gaps in valid_o.
- done_o rises on the same edge as the ROWS·COLS-th valid_o.
- Simultaneous events:
  - valid_i deasserted in the cycle the last window emerges: no effect on done_o.
  - Reset asserted with valid_o high: reset wins and all outputs go to 0 immediately (asynchronous).

## Structure
- Shared package gauss5_pkg holds:
  - KERNEL_1D = {1,4,6,4,1}
  - NORM_SHIFT = 8
  - ROUND_BIAS = 128
  - H_WIDTH = 12, S_WIDTH = 16
  - PIPE_DEPTH = 3
- Sub-module gauss_taps_1d: a combinational 1-4-6-4-1 weighted sum, parameterised by input width.
  - Instantiated 5× in stage 1 (WIDTH=8) and 1× in stage 2 (WIDTH=12).
  - Multiplications are implemented as shifts and adds (4x = <<2, 6x = <<2 + <<1).
- Top level holds the pipeline registers, valid shift register, counter and done logic.

## Test plan
- Flat window: all d*_i=100, one valid_i pulse -> pix_o=100 with valid_o exactly 3 cycles later; valid_o low otherwise.
- Centre impulse: d12_i=255, all others 0 -> pix_o=36 (9180+128>>8).
- Rounding boundary:
  - d0_i=128, rest 0 -> pix_o=1.
  - d0_i=127, rest 0 -> pix_o=0.
  - All 255 -> pix_o=255 (no overflow).
- Streaming frame (ROWS=COLS=7): 49 back-to-back random windows, checked against a reference model.
  - All 49 pix_o values match.
  - done_o rises with the 49th valid_o and stays high.
  - A 50th window yields valid_o while done_o stays 1.
- Gapped stream: valid_i pattern 1,0,0,1,1,0,1 -> valid_o shows the identical pattern delayed 3 cycles; data stays aligned.
- Reset mid-frame: assert rst_n=0 after 20 windows with 2 in flight.
  - Outputs drop to 0 asynchronously.
  - After release, a fresh 49-window frame sets done_o only on its 49th output.
